reg_scoreboard: RTL

Per-register issue scoreboard for the 24-bit, 16-register pipeline. It tracks every in-flight destination register and its remaining cycles until the result is forwardable. It raises an issue stall when a source is not yet forwardable, and on a WAW conflict. It sits beside the decode stage, feeding the decode-stage stall alongside the existing forwarding logic, and generalises the fixed load-use rule to any op latency.

---
 rtl/reg_scoreboard.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register issue scoreboard for the decode stage.
//
// Tracks every in-flight destination register together with the cycles left
// until its result can be forwarded. It stalls issue when a used source is not
// yet forwardable, and on a write-after-write conflict with a pending result.
//
// Ports:
//   i_clk, i_rst           clock; synchronous active-high reset
//   i_issue_valid          decode presents an instruction
//   i_issue_wr/_rd/_lat    destination write enable, index, forwarding latency
//   i_ra/_rb/_rc, *_used   source indices and their read enables
//   i_flush                squash the decode instruction this cycle
//   i_wb_valid, i_wb_rd    writeback retires a register
//   o_stall                hold decode/fetch (combinational)
//   o_issue_fire           instruction issues this cycle (combinational)
//   o_busy_vec             registered busy bit per register
//   o_pending              registered count of busy registers
//
// Optional feature (macro SCB_STALL_CNT_EN):
//   o_stall_cycles         saturating count of stalled cycles
//   i_stall_cnt_clr        synchronous clear; wins over increment
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned LAT_W    = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_issue_valid,
    input  logic                i_issue_wr,
    input  logic [REG_W-1:0]    i_issue_rd,
    input  logic [LAT_W-1:0]    i_issue_lat,
    input  logic [REG_W-1:0]    i_ra,
    input  logic [REG_W-1:0]    i_rb,
    input  logic [REG_W-1:0]    i_rc,
    input  logic                i_ra_used,
    input  logic                i_rb_used,
    input  logic                i_rc_used,
    input  logic                i_flush,
    input  logic                i_wb_valid,
    input  logic [REG_W-1:0]    i_wb_rd,
    output logic                o_stall,
    output logic                o_issue_fire,
    output logic [NUM_REGS-1:0] o_busy_vec,
`ifdef SCB_STALL_CNT_EN
    input  logic                i_stall_cnt_clr,
    output logic [31:0]         o_stall_cycles,
`endif
    output logic [REG_W:0]      o_pending
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_d;
    logic [LAT_W-1:0]    r_cnt   [NUM_REGS];
    logic [LAT_W-1:0]    w_cnt_d [NUM_REGS];
    logic [REG_W:0]      r_pending;
    logic [REG_W:0]      w_pending_d;

    logic w_ra_haz;
    logic w_rb_haz;
    logic w_rc_haz;
    logic w_waw_haz;
    logic w_stall;
    logic w_fire;
    logic w_fire_wr;

    // A busy register whose counter reached zero is forwardable, so only a
    // nonzero count blocks. All checks use the pre-issue state.
    assign w_ra_haz  = i_ra_used  & r_busy[i_ra]       & (r_cnt[i_ra] != '0);
    assign w_rb_haz  = i_rb_used  & r_busy[i_rb]       & (r_cnt[i_rb] != '0);
    assign w_rc_haz  = i_rc_used  & r_busy[i_rc]       & (r_cnt[i_rc] != '0);
    assign w_waw_haz = i_issue_wr & r_busy[i_issue_rd] & (r_cnt[i_issue_rd] != '0);

    assign w_stall   = i_issue_valid & ~i_flush & (w_ra_haz | w_rb_haz | w_rc_haz | w_waw_haz);
    assign w_fire    = i_issue_valid & ~w_stall & ~i_flush;
    assign w_fire_wr = w_fire & i_issue_wr;

    always_comb begin
        w_busy_d    = r_busy;
        w_pending_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_d[i] = (r_cnt[i] != '0) ? r_cnt[i] - LAT_W'(1) : '0;
            if (i_wb_valid && (i_wb_rd == REG_W'(i))) begin
                w_busy_d[i] = 1'b0;
            end
            // A same-cycle issue to the written-back register wins.
            if (w_fire_wr && (i_issue_rd == REG_W'(i))) begin
                w_busy_d[i] = 1'b1;
                w_cnt_d[i]  = i_issue_lat;
            end
            w_pending_d = w_pending_d + (REG_W + 1)'(w_busy_d[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy    <= '0;
            r_pending <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_busy    <= w_busy_d;
            r_pending <= w_pending_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

`ifdef SCB_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stall_cnt_clr) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

    assign o_stall      = w_stall;
    assign o_issue_fire = w_fire;
    assign o_busy_vec   = r_busy;
    assign o_pending    = r_pending;

endmodule
